// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - batch run controller: core reset, per-program start pulses, cycle budgets
module run_sequencer #(
  parameter int  NPROG   = 3,
  parameter int  TIMEOUT = 4096,
  parameter int  CW      = 16,
  localparam int PW      = (NPROG > 1) ? $clog2(NPROG) : 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Go,
  input  logic          CoreAck,
  output logic          CoreReset,
  output logic          CoreStart,
  output logic [PW-1:0] ProgIdx,
  output logic          Busy,
  output logic          Done,
  output logic          Timeout,
  output logic [CW-1:0] LastCycles,
  output logic [CW-1:0] TotalCycles
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [CW-1:0] TMO      = CW'(TIMEOUT);
  localparam logic [PW-1:0] LAST_IDX = PW'(NPROG - 1);

  state_t        state;
  logic [4:0]    flags;
  logic [CW-1:0] counter;
  logic          armed;
  logic [CW:0]   sum;
  logic [CW-1:0] total_sat;
  logic          accept;

  // Output flags {CoreReset, CoreStart, Busy, Done, Timeout} for the state being entered
  function automatic logic [4:0] outs(input state_t s);
    case (s)
      S_IDLE:  outs = 5'b10000;
      S_START: outs = 5'b01100;
      S_RUN:   outs = 5'b00100;
      S_DONE:  outs = 5'b00010;
      S_FAULT: outs = 5'b10001;
      default: outs = 5'b10000;
    endcase
  endfunction

  assign {CoreReset, CoreStart, Busy, Done, Timeout} = flags;

  // Running total saturates rather than wrapping
  assign sum       = {1'b0, TotalCycles} + {1'b0, counter};
  assign total_sat = sum[CW] ? '1 : sum[CW-1:0];

  // A high Ack only counts once it has been seen low since this program's START
  assign accept = armed && CoreAck;

  // Sequencer state, counters and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_IDLE;
      flags       <= outs(S_IDLE);
      ProgIdx     <= '0;
      counter     <= '0;
      armed       <= 1'b0;
      LastCycles  <= '0;
      TotalCycles <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (Go) begin
            state       <= S_START;
            flags       <= outs(S_START);
            ProgIdx     <= '0;
            TotalCycles <= '0;
          end
        end
        S_START: begin
          state   <= S_RUN;
          flags   <= outs(S_RUN);
          counter <= '0;
          armed   <= 1'b0;
        end
        S_RUN: begin
          if (!CoreAck) armed <= 1'b1;
          if (accept) begin
            LastCycles  <= counter;
            TotalCycles <= total_sat;
            if (ProgIdx == LAST_IDX) begin
              state <= S_DONE;
              flags <= outs(S_DONE);
            end else begin
              ProgIdx <= ProgIdx + 1'b1;
              state   <= S_START;
              flags   <= outs(S_START);
            end
          end else begin
            if (counter != '1) counter <= counter + 1'b1;
            if (counter == TMO) begin
              state <= S_FAULT;
              flags <= outs(S_FAULT);
            end
          end
        end
        S_FAULT: begin
          state <= S_FAULT;
        end
        default: begin
          state <= S_IDLE;
          flags <= outs(S_IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - directed self-checking bench for run_sequencer
module tb_run_sequencer;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  // sel=0 targets dut_a (NPROG=3, TIMEOUT=40), sel=1 targets dut_b (NPROG=1, TIMEOUT=8)
  logic sel   = 1'b0;
  logic Reset = 1'b1;
  logic Go    = 1'b0;
  logic Ack   = 1'b1;

  logic a_rst, a_go, a_ack, b_rst, b_go, b_ack;
  assign a_rst = Reset | sel;
  assign a_go  = Go & ~sel;
  assign a_ack = Ack | sel;
  assign b_rst = Reset | ~sel;
  assign b_go  = Go & sel;
  assign b_ack = Ack | ~sel;

  logic        a_creset, a_cstart, a_busy, a_done, a_tmo;
  logic [1:0]  a_idx;
  logic [15:0] a_last, a_total;
  logic        b_creset, b_cstart, b_busy, b_done, b_tmo;
  logic [0:0]  b_idx;
  logic [15:0] b_last, b_total;

  run_sequencer #(.NPROG(3), .TIMEOUT(40), .CW(16)) dut_a (
    .Clk(Clk), .Reset(a_rst), .Go(a_go), .CoreAck(a_ack),
    .CoreReset(a_creset), .CoreStart(a_cstart), .ProgIdx(a_idx),
    .Busy(a_busy), .Done(a_done), .Timeout(a_tmo),
    .LastCycles(a_last), .TotalCycles(a_total)
  );

  run_sequencer #(.NPROG(1), .TIMEOUT(8), .CW(16)) dut_b (
    .Clk(Clk), .Reset(b_rst), .Go(b_go), .CoreAck(b_ack),
    .CoreReset(b_creset), .CoreStart(b_cstart), .ProgIdx(b_idx),
    .Busy(b_busy), .Done(b_done), .Timeout(b_tmo),
    .LastCycles(b_last), .TotalCycles(b_total)
  );

  logic        o_creset, o_cstart, o_busy, o_done, o_tmo;
  logic [1:0]  o_idx;
  logic [15:0] o_last, o_total;
  assign o_creset = sel ? b_creset : a_creset;
  assign o_cstart = sel ? b_cstart : a_cstart;
  assign o_busy   = sel ? b_busy   : a_busy;
  assign o_done   = sel ? b_done   : a_done;
  assign o_tmo    = sel ? b_tmo    : a_tmo;
  assign o_idx    = sel ? {1'b0, b_idx} : a_idx;
  assign o_last   = sel ? b_last   : a_last;
  assign o_total  = sel ? b_total  : a_total;

  int n_checks = 0;
  int n_pass   = 0;
  int n_start  = 0;

  // flags as {CoreReset, CoreStart, Busy, Done, Timeout}
  function automatic logic [4:0] flg();
    return {o_creset, o_cstart, o_busy, o_done, o_tmo};
  endfunction

  task automatic step();
    @(negedge Clk);
    if (o_cstart) n_start++;
  endtask

  task automatic do_reset(input logic s);
    sel   = s;
    Go    = 1'b0;
    Ack   = 1'b1;
    Reset = 1'b1;
    step();
    step();
    Reset   = 1'b0;
    n_start = 0;
  endtask

  // At START's sample point: Ack high for pre RUN cycles, low for low cycles, then high (accept).
  // Returns at the sample point of the cycle after acceptance.
  task automatic core_prog(input int pre, input int low, input string name);
    int bad = 0;
    for (int r = 0; r <= pre + low; r++) begin
      step();
      if (flg() !== 5'b00100) bad++;
      Ack = (r < pre) ? 1'b1 : ((r < pre + low) ? 1'b0 : 1'b1);
    end
    step();
    n_checks++;
    if (bad !== 0) $display("FAIL %s run_flags: %0d bad RUN cycles, required 0", name, bad);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    n_checks++;
    if ({flg(), o_idx, o_last, o_total} !== {5'b10000, 2'd0, 16'd0, 16'd0})
      $display("FAIL reset_a: flags=%b idx=%0d last=%0d total=%0d, required flags=10000 idx=0 last=0 total=0",
               flg(), o_idx, o_last, o_total);
    else n_pass++;
  endtask

  task automatic test_single();
    do_reset(1'b1);
    Go = 1'b1;
    step();
    Go = 1'b0;
    n_checks++;
    if ({flg(), o_idx} !== {5'b01100, 2'd0})
      $display("FAIL single_start: flags=%b idx=%0d, required flags=01100 idx=0", flg(), o_idx);
    else n_pass++;
    core_prog(1, 5, "single");
    n_checks++;
    if ({flg(), o_last, o_total} !== {5'b00010, 16'd6, 16'd6})
      $display("FAIL single_done: flags=%b last=%0d total=%0d, required flags=00010 last=6 total=6",
               flg(), o_last, o_total);
    else n_pass++;
    step();
    step();
    n_checks++;
    if (n_start !== 1) $display("FAIL single_start_count: %0d pulses, required 1", n_start);
    else n_pass++;
  endtask

  task automatic test_batch();
    int len [3] = '{10, 20, 30};
    do_reset(1'b0);
    Go = 1'b1;
    step();
    Go = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({flg(), o_idx} !== {5'b01100, 2'(k)})
        $display("FAIL batch_start%0d: flags=%b idx=%0d, required flags=01100 idx=%0d", k, flg(), o_idx, k);
      else n_pass++;
      core_prog(0, len[k], "batch");
      n_checks++;
      if (o_last !== 16'(len[k]))
        $display("FAIL batch_last%0d: last=%0d, required %0d", k, o_last, len[k]);
      else n_pass++;
    end
    n_checks++;
    if ({flg(), o_idx, o_total} !== {5'b00010, 2'd2, 16'd60})
      $display("FAIL batch_done: flags=%b idx=%0d total=%0d, required flags=00010 idx=2 total=60",
               flg(), o_idx, o_total);
    else n_pass++;
    n_checks++;
    if (n_start !== 3) $display("FAIL batch_start_count: %0d pulses, required 3", n_start);
    else n_pass++;
  endtask

  task automatic test_stale_ack();
    do_reset(1'b1);
    Go = 1'b1;
    step();
    Go = 1'b0;
    core_prog(3, 4, "stale");
    n_checks++;
    if ({flg(), o_last} !== {5'b00010, 16'd7})
      $display("FAIL stale_ack: flags=%b last=%0d, required flags=00010 last=7", flg(), o_last);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int bad = 0;
    do_reset(1'b1);
    Go = 1'b1;
    step();
    Go = 1'b0;
    core_prog(1, 5, "pre_timeout");
    Go = 1'b1;
    step();
    Go = 1'b0;
    for (int r = 0; r <= 8; r++) begin
      step();
      if (flg() !== 5'b00100) bad++;
      Ack = 1'b0;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL timeout_run: %0d bad RUN cycles, required 0", bad);
    else n_pass++;
    step();
    n_checks++;
    if ({flg(), o_last} !== {5'b10001, 16'd6})
      $display("FAIL timeout_fault: flags=%b last=%0d, required flags=10001 last=6", flg(), o_last);
    else n_pass++;
    Go  = 1'b1;
    Ack = 1'b1;
    for (int i = 0; i < 5; i++) step();
    Go = 1'b0;
    n_checks++;
    if ({flg(), o_last} !== {5'b10001, 16'd6})
      $display("FAIL timeout_sticky: flags=%b last=%0d, required flags=10001 last=6", flg(), o_last);
    else n_pass++;
  endtask

  task automatic test_boundary();
    do_reset(1'b1);
    Go = 1'b1;
    step();
    Go = 1'b0;
    core_prog(0, 8, "boundary");
    n_checks++;
    if ({flg(), o_last, o_total} !== {5'b00010, 16'd8, 16'd8})
      $display("FAIL boundary: flags=%b last=%0d total=%0d, required flags=00010 last=8 total=8",
               flg(), o_last, o_total);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int len [3] = '{3, 4, 5};
    do_reset(1'b0);
    Go = 1'b1;
    step();
    Go = 1'b0;
    core_prog(0, 10, "mid_p0");
    n_checks++;
    if ({flg(), o_idx} !== {5'b01100, 2'd1})
      $display("FAIL mid_prog1: flags=%b idx=%0d, required flags=01100 idx=1", flg(), o_idx);
    else n_pass++;
    step();
    Ack = 1'b0;
    step();
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    Ack   = 1'b1;
    n_checks++;
    if ({flg(), o_idx, o_last, o_total} !== {5'b10000, 2'd0, 16'd0, 16'd0})
      $display("FAIL mid_reset: flags=%b idx=%0d last=%0d total=%0d, required flags=10000 idx=0 last=0 total=0",
               flg(), o_idx, o_last, o_total);
    else n_pass++;
    Go = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({flg(), o_idx} !== {5'b01100, 2'(k)})
        $display("FAIL b2b_start%0d: flags=%b idx=%0d, required flags=01100 idx=%0d", k, flg(), o_idx, k);
      else n_pass++;
      core_prog(0, len[k], "b2b");
    end
    n_checks++;
    if ({flg(), o_idx, o_last, o_total} !== {5'b00010, 2'd2, 16'd5, 16'd12})
      $display("FAIL b2b_done: flags=%b idx=%0d last=%0d total=%0d, required flags=00010 idx=2 last=5 total=12",
               flg(), o_idx, o_last, o_total);
    else n_pass++;
    step();
    Go = 1'b0;
    n_checks++;
    if ({flg(), o_idx, o_total} !== {5'b01100, 2'd0, 16'd0})
      $display("FAIL b2b_restart: flags=%b idx=%0d total=%0d, required flags=01100 idx=0 total=0",
               flg(), o_idx, o_total);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_batch();
    test_stale_ack();
    test_timeout();
    test_boundary();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
